// File: rtl/button_click_decoder.sv
// Groups single-cycle button press pulses into click bursts and reports the
// burst size once the burst closes, either by timeout or by reaching MAX_CLICKS.
module button_click_decoder #(
    parameter int WINDOW_CYCLES = 8,
    parameter int MAX_CLICKS    = 3,
    localparam int CNT_W = $clog2(MAX_CLICKS + 1),
    localparam int TMR_W = ($clog2(WINDOW_CYCLES) > 1) ? $clog2(WINDOW_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    output logic             click_valid,
    output logic [CNT_W-1:0] click_count,
    output logic             busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] ONE_TMR  = TMR_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] n_reg, n_next;
    logic [TMR_W-1:0] t_reg, t_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             busy_reg, busy_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            t_reg     <= '0;
            valid_reg <= 1'b0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            t_reg     <= t_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        t_next     = t_reg;
        valid_next = 1'b0;
        count_next = count_reg;
        busy_next  = busy_reg;
        unique case (state_reg)
            IDLE: begin
                if (pulse) begin
                    if (MAX_CLICKS == 1) begin
                        valid_next = 1'b1;
                        count_next = MAX_CNT;
                    end else begin
                        state_next = WAIT;
                        n_next     = ONE_CNT;
                        t_next     = '0;
                        busy_next  = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A press on the final window cycle extends the burst rather than closing it.
                if (pulse) begin
                    if (n_reg + ONE_CNT == MAX_CNT) begin
                        valid_next = 1'b1;
                        count_next = MAX_CNT;
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        n_next     = '0;
                        t_next     = '0;
                    end else begin
                        n_next = n_reg + ONE_CNT;
                        t_next = '0;
                    end
                end else if (t_reg == WIN_LAST) begin
                    valid_next = 1'b1;
                    count_next = n_reg;
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    n_next     = '0;
                    t_next     = '0;
                end else begin
                    t_next = t_reg + ONE_TMR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign click_valid = valid_reg;
    assign click_count = count_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_button_click_decoder.sv
// Directed bench for button_click_decoder: a timeline model of click bursts is
// compared every cycle, and hand-computed masks pin the expected edges.
module tb_button_click_decoder;

    localparam int W = 8;
    localparam int M = 3;
    localparam int CW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pulse = 1'b0;
    logic          click_valid;
    logic [CW-1:0] click_count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    button_click_decoder #(.WINDOW_CYCLES(W), .MAX_CLICKS(M)) dut (
        .clk(clk),
        .reset(reset),
        .pulse(pulse),
        .click_valid(click_valid),
        .click_count(click_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: a burst is open from its first press; it closes when it holds M
    // presses, or when W edges have passed since its latest press with no new one.
    bit m_open = 1'b0;
    int m_n = 0;
    int m_since = 0;
    bit m_valid = 1'b0;
    int m_count = 0;

    always @(posedge clk) begin
        m_valid = 1'b0;
        if (reset) begin
            m_open = 1'b0; m_n = 0; m_since = 0; m_count = 0;
        end else if (m_open) begin
            if (pulse) begin
                m_n++;
                m_since = 0;
                if (m_n == M) begin
                    m_valid = 1'b1; m_count = m_n; m_open = 1'b0;
                end
            end else begin
                m_since++;
                if (m_since == W) begin
                    m_valid = 1'b1; m_count = m_n; m_open = 1'b0;
                end
            end
        end else if (pulse) begin
            if (M == 1) begin
                m_valid = 1'b1; m_count = 1;
            end else begin
                m_open = 1'b1; m_n = 1; m_since = 0;
            end
        end
    end

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model valid", int'(click_valid), int'(m_valid));
            chk("model count", int'(click_count), m_count);
            chk("model busy", int'(busy), int'(m_open));
            if (click_valid) $display("click burst closed: count=%0d", click_count);
        end
    end

    function automatic logic [63:0] bits(int lo, int hi);
        return (64'd1 << (hi + 1)) - (64'd1 << lo);
    endfunction

    function automatic logic [63:0] b(int k);
        return 64'd1 << k;
    endfunction

    // Edge 0 always carries reset; bit k of each mask refers to edge k.
    task automatic run(string name, logic [63:0] pm, logic [63:0] rm,
                       logic [63:0] vexp, logic [63:0] bexp,
                       int c0, int c1, int c_end, int len);
        int nv = 0;
        $display("test %s", name);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            reset = (k == 0) || rm[k];
            pulse = pm[k];
            @(posedge clk);
            #1;
            chk_on = 1'b1;
            chk({name, " valid"}, int'(click_valid), int'(vexp[k]));
            chk({name, " busy"}, int'(busy), int'(bexp[k]));
            if (k == 0) chk({name, " reset count"}, int'(click_count), 0);
            if (vexp[k]) begin
                chk({name, " count"}, int'(click_count), (nv == 0) ? c0 : c1);
                nv++;
            end
        end
        chk({name, " final count"}, int'(click_count), c_end);
    endtask

    initial begin
        run("single", b(10), 64'd0, b(18), bits(10, 17), 1, 0, 1, 30);
        run("double", b(10) | b(15), 64'd0, b(23), bits(10, 22), 2, 0, 2, 32);
        run("max_close", b(10) | b(12) | b(14), 64'd0, b(14), bits(10, 13), 3, 0, 3, 30);
        run("late_pulse", b(10) | b(17), 64'd0, b(25), bits(10, 24), 2, 0, 2, 34);
        run("boundary", b(10) | b(18), 64'd0, b(26), bits(10, 25), 2, 0, 2, 34);
        run("reset_mid", b(10) | b(12) | b(13), b(13), 64'd0, bits(10, 12), 0, 0, 0, 30);
        run("back2back", b(10) | b(12) | b(14) | b(15), 64'd0, b(14) | b(23),
            bits(10, 13) | bits(15, 22), 3, 1, 1, 32);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
